pio_tx_fifo_ctrl: RTL and testbench

PIO_TX_FIFO_CTRL -- requirements
Module: pio_tx_fifo_ctrl

---
 rtl/pio_tx_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_pio_tx_fifo_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_tx_fifo_ctrl.sv
// Four independent TX FIFOs fed from one shared bus push port and drained by
// per-state-machine pop strobes, with sticky overflow/underflow reporting.
module pio_tx_fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_pushValid,
    input  logic [1:0]                        in_pushSel,
    input  logic [WIDTH-1:0]                  in_pushData,
    output logic                              out_pushAck,
    input  logic [3:0]                        in_popAck,
    output logic [4*WIDTH-1:0]                out_headData,
    output logic [3:0]                        out_empty,
    output logic [3:0]                        out_full,
    output logic [4*($clog2(DEPTH)+1)-1:0]    out_level,
    input  logic [3:0]                        in_flush,
    input  logic                              in_clearFlags,
    output logic [3:0]                        out_overflow,
    output logic [3:0]                        out_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem    [4][DEPTH];
    logic [PW-1:0]    rd_ptr [4];
    logic [PW-1:0]    wr_ptr [4];
    logic [LW-1:0]    level  [4];

    logic [3:0] push_hit;
    logic [3:0] push_ok;
    logic [3:0] pop_ok;
    logic [3:0] ovf_ev;
    logic [3:0] udf_ev;

    // A full FIFO still takes a push when its head leaves in the same cycle;
    // flush masks both the push and the underflow report.
    always_comb begin
        push_hit = '0;
        push_ok  = '0;
        pop_ok   = '0;
        ovf_ev   = '0;
        udf_ev   = '0;
        for (int n = 0; n < 4; n++) begin
            push_hit[n] = in_pushValid && (in_pushSel == 2'(n)) && !in_flush[n];
            pop_ok[n]   = in_popAck[n] && (level[n] != '0);
            push_ok[n]  = push_hit[n] && ((level[n] != FULL_LVL) || in_popAck[n]);
            ovf_ev[n]   = push_hit[n] && !push_ok[n];
            udf_ev[n]   = in_popAck[n] && (level[n] == '0) && !in_flush[n];
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (push_ok[n] && !reset) begin
                mem[n][wr_ptr[n]] <= in_pushData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_pushAck   <= 1'b0;
            out_overflow  <= '0;
            out_underflow <= '0;
            for (int n = 0; n < 4; n++) begin
                rd_ptr[n] <= '0;
                wr_ptr[n] <= '0;
                level[n]  <= '0;
            end
        end else begin
            out_pushAck <= |push_ok;
            for (int n = 0; n < 4; n++) begin
                out_overflow[n]  <= (out_overflow[n]  && !in_clearFlags) || ovf_ev[n];
                out_underflow[n] <= (out_underflow[n] && !in_clearFlags) || udf_ev[n];
                if (in_flush[n]) begin
                    rd_ptr[n] <= '0;
                    wr_ptr[n] <= '0;
                    level[n]  <= '0;
                end else begin
                    if (push_ok[n]) wr_ptr[n] <= wr_ptr[n] + 1'b1;
                    if (pop_ok[n])  rd_ptr[n] <= rd_ptr[n] + 1'b1;
                    level[n] <= level[n] + {{(LW-1){1'b0}}, push_ok[n]}
                                         - {{(LW-1){1'b0}}, pop_ok[n]};
                end
            end
        end
    end

    always_comb begin
        out_headData = '0;
        out_empty    = '0;
        out_full     = '0;
        out_level    = '0;
        for (int n = 0; n < 4; n++) begin
            out_empty[n]            = (level[n] == '0);
            out_full[n]             = (level[n] == FULL_LVL);
            out_level[n*LW +: LW]   = level[n];
            if (level[n] != '0) begin
                out_headData[n*WIDTH +: WIDTH] = mem[n][rd_ptr[n]];
            end
        end
    end

endmodule

// File: tb/tb_pio_tx_fifo_ctrl.sv
// Directed bench for pio_tx_fifo_ctrl with DEPTH=4, WIDTH=32.
module tb_pio_tx_fifo_ctrl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int LW    = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_pushValid;
    logic [1:0]        in_pushSel;
    logic [WIDTH-1:0]  in_pushData;
    logic              out_pushAck;
    logic [3:0]        in_popAck;
    logic [4*WIDTH-1:0] out_headData;
    logic [3:0]        out_empty;
    logic [3:0]        out_full;
    logic [4*LW-1:0]   out_level;
    logic [3:0]        in_flush;
    logic              in_clearFlags;
    logic [3:0]        out_overflow;
    logic [3:0]        out_underflow;

    int total = 0;
    int bad   = 0;

    pio_tx_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_pushValid(in_pushValid), .in_pushSel(in_pushSel), .in_pushData(in_pushData),
        .out_pushAck(out_pushAck), .in_popAck(in_popAck), .out_headData(out_headData),
        .out_empty(out_empty), .out_full(out_full), .out_level(out_level),
        .in_flush(in_flush), .in_clearFlags(in_clearFlags),
        .out_overflow(out_overflow), .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] lvl(input int n);
        return out_level[n*LW +: LW];
    endfunction

    function automatic logic [WIDTH-1:0] head(input int n);
        return out_headData[n*WIDTH +: WIDTH];
    endfunction

    task automatic idle();
        in_pushValid  = 1'b0;
        in_pushSel    = 2'd0;
        in_pushData   = '0;
        in_popAck     = 4'h0;
        in_flush      = 4'h0;
        in_clearFlags = 1'b0;
    endtask

    // Apply the current inputs at the next rising edge, then settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] sel, input logic [WIDTH-1:0] d);
        in_pushValid = 1'b1;
        in_pushSel   = sel;
        in_pushData  = d;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        push(2'd0, 32'hDEAD_0000);
        step();
        step();
        total++; if (out_empty !== 4'hF) begin bad++; $display("FAIL rst_empty got %h want F", out_empty); end
        total++; if (out_full !== 4'h0) begin bad++; $display("FAIL rst_full got %h want 0", out_full); end
        total++; if (out_level !== '0) begin bad++; $display("FAIL rst_level got %h want 0", out_level); end
        total++; if (out_headData !== '0) begin bad++; $display("FAIL rst_head got %h want 0", out_headData); end
        total++; if (out_pushAck !== 1'b0) begin bad++; $display("FAIL rst_ack got %b want 0", out_pushAck); end
        total++; if (out_overflow !== 4'h0 || out_underflow !== 4'h0) begin bad++; $display("FAIL rst_flags got %h/%h want 0/0", out_overflow, out_underflow); end
        reset = 1'b0;
        idle();
        step();
        total++; if (lvl(0) !== 3'd0) begin bad++; $display("FAIL rst_push_dropped level0 got %0d want 0", lvl(0)); end
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] a [4];
        a[0] = 32'hA1; a[1] = 32'hA2; a[2] = 32'hA3; a[3] = 32'hA4;
        total++; if (out_pushAck !== 1'b0) begin bad++; $display("FAIL fill_ack_pre got %b want 0", out_pushAck); end
        for (int i = 0; i < 4; i++) begin
            push(2'd0, a[i]);
            step();
            total++; if (out_pushAck !== 1'b1) begin bad++; $display("FAIL fill_ack%0d got %b want 1", i, out_pushAck); end
            total++; if (lvl(0) !== 3'(i + 1)) begin bad++; $display("FAIL fill_level%0d got %0d want %0d", i, lvl(0), i + 1); end
        end
        idle();
        step();
        total++; if (out_pushAck !== 1'b0) begin bad++; $display("FAIL fill_ack_post got %b want 0", out_pushAck); end
        total++; if (out_full[0] !== 1'b1) begin bad++; $display("FAIL fill_full0 got %b want 1", out_full[0]); end
        total++; if (head(0) !== 32'hA1) begin bad++; $display("FAIL fill_head0 got %h want A1", head(0)); end
    endtask

    task automatic test_overflow();
        push(2'd0, 32'hA5);
        step();
        idle();
        total++; if (out_pushAck !== 1'b0) begin bad++; $display("FAIL ovf_ack got %b want 0", out_pushAck); end
        total++; if (out_overflow !== 4'h1) begin bad++; $display("FAIL ovf_flag got %h want 1", out_overflow); end
        total++; if (head(0) !== 32'hA1 || lvl(0) !== 3'd4) begin bad++; $display("FAIL ovf_state head %h lvl %0d want A1 4", head(0), lvl(0)); end
        in_clearFlags = 1'b1;
        step();
        total++; if (out_overflow !== 4'h0) begin bad++; $display("FAIL ovf_clear got %h want 0", out_overflow); end
        push(2'd0, 32'hA6);
        step();
        idle();
        total++; if (out_overflow[0] !== 1'b1) begin bad++; $display("FAIL ovf_event_wins got %b want 1", out_overflow[0]); end
        in_clearFlags = 1'b1;
        step();
        idle();
        total++; if (out_overflow !== 4'h0) begin bad++; $display("FAIL ovf_clear2 got %h want 0", out_overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            push(2'd2, 32'hB000_0000 + 32'(i));
            step();
        end
        push(2'd2, 32'hBBBB_BBBB);
        in_popAck = 4'h4;
        step();
        idle();
        total++; if (out_pushAck !== 1'b1) begin bad++; $display("FAIL fpp_ack got %b want 1", out_pushAck); end
        total++; if (lvl(2) !== 3'd4 || out_full[2] !== 1'b1) begin bad++; $display("FAIL fpp_level got %0d full %b want 4 1", lvl(2), out_full[2]); end
        total++; if (head(2) !== 32'hB000_0001) begin bad++; $display("FAIL fpp_head got %h want B0000001", head(2)); end
        total++; if (out_overflow[2] !== 1'b0) begin bad++; $display("FAIL fpp_no_ovf got %b want 0", out_overflow[2]); end
        in_popAck = 4'h4; step();
        total++; if (head(2) !== 32'hB000_0002) begin bad++; $display("FAIL fpp_pop1 got %h want B0000002", head(2)); end
        step();
        total++; if (head(2) !== 32'hB000_0003) begin bad++; $display("FAIL fpp_pop2 got %h want B0000003", head(2)); end
        step();
        total++; if (head(2) !== 32'hBBBB_BBBB || lvl(2) !== 3'd1) begin bad++; $display("FAIL fpp_last got %h lvl %0d want BBBBBBBB 1", head(2), lvl(2)); end
        step();
        idle();
        total++; if (out_empty[2] !== 1'b1 || head(2) !== '0) begin bad++; $display("FAIL fpp_empty got %b head %h want 1 0", out_empty[2], head(2)); end
    endtask

    task automatic test_underflow();
        push(2'd1, 32'hC0C0_C0C0);
        in_popAck = 4'h2;
        step();
        idle();
        total++; if (out_underflow !== 4'h2) begin bad++; $display("FAIL udf_flag got %h want 2", out_underflow); end
        total++; if (lvl(1) !== 3'd1 || out_pushAck !== 1'b1) begin bad++; $display("FAIL udf_level got %0d ack %b want 1 1", lvl(1), out_pushAck); end
        total++; if (head(1) !== 32'hC0C0_C0C0) begin bad++; $display("FAIL udf_head got %h want C0C0C0C0", head(1)); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            push(2'd3, 32'h3000_0000 + 32'(i));
            step();
        end
        idle();
        step();
        total++; if (lvl(3) !== 3'd3) begin bad++; $display("FAIL flush_pre got %0d want 3", lvl(3)); end
        push(2'd3, 32'hD0D0_D0D0);
        in_flush = 4'h8;
        step();
        idle();
        total++; if (lvl(3) !== 3'd0 || out_empty[3] !== 1'b1) begin bad++; $display("FAIL flush_level got %0d empty %b want 0 1", lvl(3), out_empty[3]); end
        total++; if (out_pushAck !== 1'b0) begin bad++; $display("FAIL flush_ack got %b want 0", out_pushAck); end
        total++; if (out_overflow[3] !== 1'b0 || head(3) !== '0) begin bad++; $display("FAIL flush_ovf got %b head %h want 0 0", out_overflow[3], head(3)); end
    endtask

    task automatic test_wrap();
        in_flush = 4'h1;
        step();
        idle();
        for (int i = 0; i < 3 * DEPTH + 1; i++) begin
            push(2'd0, 32'h5A00_0000 + 32'(i));
            step();
            idle();
            total++; if (lvl(0) !== 3'd1 || head(0) !== 32'h5A00_0000 + 32'(i)) begin bad++; $display("FAIL wrap_push%0d lvl %0d head %h want 1 %h", i, lvl(0), head(0), 32'h5A00_0000 + 32'(i)); end
            in_popAck = 4'h1;
            step();
            idle();
            total++; if (lvl(0) !== 3'd0) begin bad++; $display("FAIL wrap_pop%0d lvl %0d want 0", i, lvl(0)); end
        end
    endtask

    task automatic test_all_pops();
        in_flush = 4'hF;
        step();
        idle();
        for (int n = 0; n < 4; n++) begin
            push(2'(n), 32'h7000_0000 + 32'(n));
            step();
        end
        push(2'd1, 32'h7777_7777);
        in_popAck = 4'hF;
        step();
        idle();
        total++; if (out_empty !== 4'hD || lvl(1) !== 3'd1) begin bad++; $display("FAIL allpop_empty got %h lvl1 %0d want D 1", out_empty, lvl(1)); end
        total++; if (head(1) !== 32'h7777_7777 || out_pushAck !== 1'b1) begin bad++; $display("FAIL allpop_head got %h ack %b want 77777777 1", head(1), out_pushAck); end
    endtask

    task automatic test_reset_mid();
        push(2'd0, 32'hE000_0001); step();
        push(2'd0, 32'hE000_0002); step();
        idle();
        in_popAck = 4'h8; step();
        idle();
        total++; if (lvl(0) !== 3'd2 || out_underflow[3] !== 1'b1) begin bad++; $display("FAIL rmid_pre lvl %0d udf %b want 2 1", lvl(0), out_underflow[3]); end
        reset = 1'b1;
        push(2'd0, 32'hE000_0003);
        step();
        reset = 1'b0;
        idle();
        total++; if (out_level !== '0 || out_empty !== 4'hF || out_full !== 4'h0) begin bad++; $display("FAIL rmid_status lvl %h empty %h full %h want 0 F 0", out_level, out_empty, out_full); end
        total++; if (out_headData !== '0 || out_pushAck !== 1'b0 || out_underflow !== 4'h0 || out_overflow !== 4'h0) begin bad++; $display("FAIL rmid_out head %h ack %b flags %h/%h want 0", out_headData, out_pushAck, out_overflow, out_underflow); end
        push(2'd0, 32'hE000_00FF);
        step();
        idle();
        total++; if (head(0) !== 32'hE000_00FF || lvl(0) !== 3'd1) begin bad++; $display("FAIL rmid_newhead got %h lvl %0d want E00000FF 1", head(0), lvl(0)); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_underflow();
        test_flush();
        test_wrap();
        test_all_pops();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
